// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and the
// 1149.1 state transition function used by the controller FSM.
package jtag_pkg;

   typedef enum logic [3:0] {
      EX2_DR   = 4'h0,
      EX1_DR   = 4'h1,
      SH_DR    = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EX2_IR   = 4'h8,
      EX1_IR   = 4'h9,
      SH_IR    = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_t;

   localparam logic [3:0] EXTEST     = 4'b0000;
   localparam logic [3:0] SAMPLE     = 4'b0001;
   localparam logic [3:0] IDCODE     = 4'b0010;
   localparam logic [3:0] BYPASS     = 4'b1111;
   localparam logic [3:0] IR_CAPTURE = 4'b0001;

   function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
      case (s)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EX1_DR   : SH_DR;
         SH_DR:    return tms ? EX1_DR   : SH_DR;
         EX1_DR:   return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   return tms ? UPD_DR   : SH_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EX1_IR   : SH_IR;
         SH_IR:    return tms ? EX1_IR   : SH_IR;
         EX1_IR:   return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   return tms ? UPD_IR   : SH_IR;
         UPD_IR:   return tms ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state register with next-state logic and the per-state decodes
// consumed by the register datapath in tap_controller.
module tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst_n,
   input  logic       tms,
   output tap_state_t state,
   output logic       in_tlr,
   output logic       in_cap_dr,
   output logic       in_sh_dr,
   output logic       in_upd_dr,
   output logic       in_cap_ir,
   output logic       in_sh_ir,
   output logic       in_upd_ir
);

   tap_state_t state_nxt;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of the order the simulator evaluates blocks.
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) state <= TLR;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = next_state(state, tms);
      in_tlr    = 1'b0;
      in_cap_dr = 1'b0;
      in_sh_dr  = 1'b0;
      in_upd_dr = 1'b0;
      in_cap_ir = 1'b0;
      in_sh_ir  = 1'b0;
      in_upd_ir = 1'b0;
      case (state)
         TLR:     in_tlr    = 1'b1;
         CAP_DR:  in_cap_dr = 1'b1;
         SH_DR:   in_sh_dr  = 1'b1;
         UPD_DR:  in_upd_dr = 1'b1;
         CAP_IR:  in_cap_ir = 1'b1;
         SH_IR:   in_sh_ir  = 1'b1;
         UPD_IR:  in_upd_ir = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/tap_controller.sv
// 1149.1 TAP controller: IR, bypass and IDCODE registers, boundary-scan
// chain strobes and the falling-edge tdo mux.
module tap_controller
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH     = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
   input  logic                tck,
   input  logic                trst_n,
   input  logic                tms,
   input  logic                tdi,
   output logic                bsr_si,
   input  logic                bsr_so,
   output logic                clock_dr,
   output logic                shift_dr,
   output logic                update_dr,
   output logic                mode,
   output logic                tdo,
   output logic                tdo_en,
   output logic [IR_WIDTH-1:0] ir_o,
   output logic [3:0]          state_o
);

   tap_state_t          state;
   logic                in_tlr, in_cap_dr, in_sh_dr, in_upd_dr;
   logic                in_cap_ir, in_sh_ir, in_upd_ir;
   logic [IR_WIDTH-1:0] ir_shift, ir_active;
   logic                bypass_reg;
   logic [31:0]         idcode_reg;
   logic                sel_bsr, sel_idcode, sel_bypass;

   tap_fsm u_fsm (
      .tck       (tck),
      .trst_n    (trst_n),
      .tms       (tms),
      .state     (state),
      .in_tlr    (in_tlr),
      .in_cap_dr (in_cap_dr),
      .in_sh_dr  (in_sh_dr),
      .in_upd_dr (in_upd_dr),
      .in_cap_ir (in_cap_ir),
      .in_sh_ir  (in_sh_ir),
      .in_upd_ir (in_upd_ir)
   );

   // Unassigned codes fall through to the bypass path.
   always_comb begin
      sel_bsr    = 1'b0;
      sel_idcode = 1'b0;
      sel_bypass = 1'b0;
      if (ir_active == IR_WIDTH'(EXTEST) || ir_active == IR_WIDTH'(SAMPLE)) sel_bsr = 1'b1;
      else if (ir_active == IR_WIDTH'(IDCODE))                             sel_idcode = 1'b1;
      else                                                                 sel_bypass = 1'b1;
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n)                 ir_shift <= IR_WIDTH'(IR_CAPTURE);
      else if (in_tlr || in_cap_ir) ir_shift <= IR_WIDTH'(IR_CAPTURE);
      else if (in_sh_ir)           ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
   end

   // The active instruction changes on the falling edge so mode and the DR
   // selection never move while the rising-edge logic is sampling them.
   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n)        ir_active <= IR_WIDTH'(IDCODE);
      else if (in_tlr)    ir_active <= IR_WIDTH'(IDCODE);
      else if (in_upd_ir) ir_active <= ir_shift;
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n)                      bypass_reg <= 1'b0;
      else if (in_cap_dr && sel_bypass) bypass_reg <= 1'b0;
      else if (in_sh_dr && sel_bypass)  bypass_reg <= tdi;
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n)                      idcode_reg <= IDCODE_VALUE;
      else if (in_cap_dr && sel_idcode) idcode_reg <= IDCODE_VALUE;
      else if (in_sh_dr && sel_idcode)  idcode_reg <= {tdi, idcode_reg[31:1]};
   end

   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tdo    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         tdo_en <= in_sh_ir | in_sh_dr;
         if (in_sh_ir)                   tdo <= ir_shift[0];
         else if (in_sh_dr && sel_bsr)    tdo <= bsr_so;
         else if (in_sh_dr && sel_idcode) tdo <= idcode_reg[0];
         else if (in_sh_dr)               tdo <= bypass_reg;
      end
   end

   // Strobes are decoded only from flops and gated by the low tck phase;
   // inputs settle while tck is high, so the gated pulses cannot glitch.
   assign clock_dr  = ~tck & (in_cap_dr | in_sh_dr) & sel_bsr;
   assign update_dr = ~tck & in_upd_dr & sel_bsr;
   assign shift_dr  = in_sh_dr & sel_bsr;
   assign mode      = (ir_active == IR_WIDTH'(EXTEST));
   assign bsr_si    = tdi;
   assign ir_o      = ir_active;
   assign state_o   = state;

endmodule
